// File: rtl/systolic_pkg.sv
// systolic_pkg: shared tile defaults and drain FSM state type
package systolic_pkg;
  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OUT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} drain_state_t;
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one-lane rounding arithmetic right shift then saturation to OUT_WIDTH
// Ports: acc (signed accumulator), shift (right-shift amount), q (signed requantized result)
// Build option: DRAIN_RELU_EN forces negative results to zero after saturation.
module requant_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [OUT_WIDTH-1:0]  q
);
  logic [DATA_WIDTH:0] rnd, sum, t;
  logic [OUT_WIDTH-1:0] sat;
  logic fits;
  // half-LSB of the shifted result; shifting a one left then right yields 0 for shift==0
  assign rnd = ({{DATA_WIDTH{1'b0}}, 1'b1} << shift) >> 1;
  assign sum = {acc[DATA_WIDTH-1], acc} + rnd;
  assign t = $signed(sum) >>> shift;
  // result fits when every bit above the output sign bit equals the sign
  assign fits = &t[DATA_WIDTH:OUT_WIDTH-1] | ~|t[DATA_WIDTH:OUT_WIDTH-1];
  assign sat = fits ? t[OUT_WIDTH-1:0] : {t[DATA_WIDTH], {(OUT_WIDTH-1){~t[DATA_WIDTH]}}};
`ifdef DRAIN_RELU_EN
  assign q = sat[OUT_WIDTH-1] ? '0 : sat;
`else
  assign q = sat;
`endif
endmodule

// File: rtl/output_drain_requant.sv
// output_drain_requant: drains ARRAY_SIZE buffer rows, requantizes them and streams them out
// Ports: clk, rst (async, active-high), start/shift_amt (tile request), busy,
//        buf_read/buf_data (output buffer read side), out_valid/out_ready/out_data/out_last
//        (downstream stream), done (pulse after last row handshake).
// Build option: DRAIN_RELU_EN enables per-lane ReLU inside requant_lane.
module output_drain_requant
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT_W = $clog2(DATA_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [SHIFT_W-1:0]                   shift_amt,
  output logic                                 busy,
  output logic                                 buf_read,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] buf_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0] out_data,
  output logic                                 out_last,
  output logic                                 done
);
  localparam int CW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1;
  drain_state_t state;
  logic [CW-1:0] row_cnt;
  logic [SHIFT_W-1:0] shift_q;
  logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0] rq;
  logic last_row;
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    requant_lane #(.DATA_WIDTH(DATA_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_W(SHIFT_W)) u_lane (
      .acc(buf_data[i]),
      .shift(shift_q),
      .q(rq[i])
    );
  end
  assign busy = state != IDLE;
  // read only when the single output register is empty or being emptied this cycle
  assign buf_read = state == DRAIN && (!out_valid || out_ready);
  assign last_row = row_cnt == CW'(ARRAY_SIZE - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      row_cnt <= '0;
      shift_q <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= DRAIN;
            row_cnt <= '0;
            shift_q <= shift_amt;
          end
        DRAIN:
          if (buf_read) begin
            out_data <= rq;
            out_valid <= 1'b1;
            out_last <= last_row;
            row_cnt <= row_cnt + 1'b1;
            if (last_row) state <= FLUSH;
          end
        FLUSH:
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_output_drain_requant.sv
// tb_output_drain_requant: directed self-checking bench for output_drain_requant (ARRAY_SIZE=4)
module tb_output_drain_requant;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [4:0] shift_amt = '0;
  logic busy, buf_read, out_valid, out_last, done;
  logic out_ready = 1'b1;
  logic [127:0] buf_data = '0;
  logic [31:0] out_data;
  logic [127:0] rows [4];
  logic [31:0] expd [4];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  output_drain_requant #(.ARRAY_SIZE(4), .DATA_WIDTH(32), .OUT_WIDTH(8), .SHIFT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .shift_amt(shift_amt),
    .busy(busy),
    .buf_read(buf_read),
    .buf_data(buf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .done(done)
  );
  function automatic logic [127:0] rp(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction
  function automatic logic [31:0] op(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_tile(input logic [4:0] sh, input int stall, input bit spam, input int exp_cyc);
    int idx, beats, reads, cyc, st;
    bit seen_done, prev_stall, stl;
    logic [31:0] prev;
    idx = 0; beats = 0; reads = 0; cyc = 0; st = 0;
    seen_done = 0; prev_stall = 0; prev = '0;
    @(negedge clk);
    shift_amt = sh;
    start = 1'b1;
    out_ready = 1'b1;
    buf_data = rows[0];
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      shift_amt = ~sh;
      out_ready = !(beats >= 1 && st < stall);
      buf_data = rows[idx % 4];
      #1;
      stl = out_valid && !out_ready;
      if (stl) begin
        st++;
        chk("stall_no_read", 32'(buf_read), 32'd0);
        if (prev_stall) chk("stall_hold_data", out_data, prev);
      end
      if (stall == 0) chk("read_pattern", 32'(buf_read), 32'(cyc <= 4));
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, expd[beats % 4]);
        chk("beat_last", 32'(out_last), 32'(beats == 3));
        beats++;
      end
      prev = out_data;
      prev_stall = stl;
      if (buf_read) begin
        idx++;
        reads++;
      end
      if (done) seen_done = 1;
      start = spam && !done;
    end
    chk("reads", reads, 4);
    chk("beats", beats, 4);
    chk("start_to_done", cyc, exp_cyc);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after", {29'd0, busy, buf_read, done}, 32'd0);
  endtask
  initial begin
    int reads;
    for (int i = 0; i < 4; i++) rows[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {28'd0, busy, buf_read, out_valid, out_last}, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    rst = 1'b0;
    // passthrough
    for (int i = 0; i < 4; i++) begin
      rows[i] = rp(5, -3, 127, -128);
      expd[i] = op(5, -3, 127, -128);
    end
    run_tile(5'd0, 0, 0, 6);
    // saturation and rounding with shift 2
    rows[0] = rp(1000, -1000, 508, -516); expd[0] = op(127, -128, 127, -128);
    rows[1] = rp(6, -6, 5, 0);            expd[1] = op(2, -1, 1, 0);
    rows[2] = rp(0, 0, 0, 0);             expd[2] = op(0, 0, 0, 0);
    rows[3] = rp(4, -4, 3, -3);           expd[3] = op(1, -1, 1, -1);
    run_tile(5'd2, 0, 0, 6);
    // shift 1 with backpressure after the first beat
    rows[0] = rp(5, -5, 1, -1);           expd[0] = op(3, -2, 1, 0);
    rows[1] = rp(10, 20, 30, 40);         expd[1] = op(5, 10, 15, 20);
    rows[2] = rp(-10, -20, 254, 255);     expd[2] = op(-5, -10, 127, 127);
    rows[3] = rp(1, 2, 3, 4);             expd[3] = op(1, 1, 2, 2);
    run_tile(5'd1, 3, 0, 9);
    // start pulses throughout DRAIN and FLUSH are ignored
    run_tile(5'd1, 0, 1, 6);
    // reset after the second read
    @(negedge clk);
    shift_amt = 5'd0;
    start = 1'b1;
    buf_data = rows[0];
    reads = 0;
    for (int c = 0; c < 20 && reads < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      buf_data = rows[reads];
      #1;
      if (buf_read) reads++;
    end
    chk("pre_reset_reads", reads, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {27'd0, busy, buf_read, out_valid, out_last, done}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rows[0] = rp(-1, 1, 2, -2);           expd[0] = op(-1, 1, 2, -2);
    rows[1] = rp(7, 8, 9, 10);            expd[1] = op(7, 8, 9, 10);
    rows[2] = rp(-7, -8, -9, -10);        expd[2] = op(-7, -8, -9, -10);
    rows[3] = rp(100, -100, 0, 1);        expd[3] = op(100, -100, 0, 1);
    run_tile(5'd0, 0, 0, 6);
    // ReLU behaviour depends on the build
    rows[0] = rp(-50, 50, 0, -1);
    rows[1] = rp(-50, 50, 0, -1);
    rows[2] = rp(-300, 300, -2, 2);
    rows[3] = rp(-50, 50, 0, -1);
`ifdef DRAIN_RELU_EN
    expd[0] = op(0, 50, 0, 0);
    expd[1] = op(0, 50, 0, 0);
    expd[2] = op(0, 127, 0, 2);
    expd[3] = op(0, 50, 0, 0);
`else
    expd[0] = op(-50, 50, 0, -1);
    expd[1] = op(-50, 50, 0, -1);
    expd[2] = op(-128, 127, -2, 2);
    expd[3] = op(-50, 50, 0, -1);
`endif
    run_tile(5'd0, 0, 0, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
